// File: rtl/keypad_pkg.sv
// Shared types for the 4x4 keypad scanner: geometry, press-FSM states and
// the single/multi key classifier used on debounced snapshots.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  typedef enum logic {
    WAIT_PRESS   = 1'b0,
    WAIT_RELEASE = 1'b1
  } press_st_e;

  typedef enum logic [1:0] {
    OH_NONE,
    OH_SINGLE,
    OH_MULTI
  } oh_kind_e;

  typedef struct packed {
    oh_kind_e   kind;
    logic [3:0] idx;
  } oh_res_t;

  function automatic oh_res_t onehot16(input logic [NUM_KEYS-1:0] v);
    oh_res_t    res;
    logic [4:0] n;
    res.kind = OH_NONE;
    res.idx  = '0;
    n        = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) begin
        n       = n + 5'd1;
        res.idx = 4'(i);
      end
    end
    if (n == 5'd1)     res.kind = OH_SINGLE;
    else if (n > 5'd1) res.kind = OH_MULTI;
    return res;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Assembles per-column row samples into 16-key snapshots and promotes a
// snapshot to "stable" once DEB_SCANS consecutive scans agree.
import keypad_pkg::*;

module keypad_debounce #(
  parameter int DEB_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_vld,
  input  logic [1:0]          col_idx,
  input  logic [NUM_ROWS-1:0] rows_dn,
  output logic [NUM_KEYS-1:0] stable,
  output logic                stable_upd
);

  localparam logic [3:0] DEB = 4'(DEB_SCANS);

  logic [NUM_ROWS-1:0][NUM_COLS-1:0] snap_q, snap_d, prev_q, stable_q;
  logic [3:0]                        cnt_q, cnt_d;
  logic                              upd_q;

  // snap_d is the snapshot with the current column merged in; at column 3 it is complete.
  always_comb begin
    snap_d = snap_q;
    for (int r = 0; r < NUM_ROWS; r++) snap_d[r][col_idx] = rows_dn[r];
    if (snap_d != prev_q)  cnt_d = 4'd1;
    else if (cnt_q == DEB) cnt_d = cnt_q;
    else                   cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q   <= '0;
      prev_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      upd_q    <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      if (sample_vld) begin
        snap_q <= snap_d;
        if (col_idx == 2'd3) begin
          prev_q <= snap_d;
          cnt_q  <= cnt_d;
          if (cnt_d == DEB) begin
            stable_q <= snap_d;
            upd_q    <= 1'b1;
          end
        end
      end
    end
  end

  assign stable     = stable_q;
  assign stable_upd = upd_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column strobe, row synchronizer, debounce, and a
// press FSM that turns clean single-key presses into valid/ready key codes.
import keypad_pkg::*;

module keypad_scanner #(
  parameter int NUMSVAR   = 16,
  parameter int DEB_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [3:0]          key,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                pressed,
  output logic                overrun
);

  localparam logic [NUMSVAR-1:0] S_ONE = NUMSVAR'(1);

  logic [NUMSVAR-1:0]  s_q;
  logic [1:0]          col_idx_q;
  logic [NUM_ROWS-1:0] row_s1_q, row_s2_q;
  logic                tick;
  logic [NUM_KEYS-1:0] stable;
  logic                stable_upd;

  press_st_e  state_q, state_d;
  logic [3:0] key_q, key_d;
  logic       key_valid_q, key_valid_d;
  logic       overrun_q, overrun_d;
  logic       evt, hs;
  oh_res_t    oh;

  assign tick = &s_q;
  assign col  = ~(4'b0001 << col_idx_q);

  // Sync flops reset to all-ones so nothing looks pressed before the first real sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q       <= '0;
      col_idx_q <= '0;
      row_s1_q  <= '1;
      row_s2_q  <= '1;
    end else begin
      s_q      <= s_q + S_ONE;
      row_s1_q <= row;
      row_s2_q <= row_s1_q;
      if (tick) col_idx_q <= col_idx_q + 2'd1;
    end
  end

  keypad_debounce #(.DEB_SCANS(DEB_SCANS)) u_deb (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_vld (tick),
    .col_idx    (col_idx_q),
    .rows_dn    (~row_s2_q),
    .stable     (stable),
    .stable_upd (stable_upd)
  );

  always_comb begin
    oh          = onehot16(stable);
    hs          = key_valid_q & key_ready;
    evt         = 1'b0;
    state_d     = state_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    if (stable_upd) begin
      case (state_q)
        WAIT_PRESS: begin
          if (oh.kind == OH_SINGLE) begin
            evt     = 1'b1;
            state_d = WAIT_RELEASE;
          end else if (oh.kind == OH_MULTI) begin
            state_d = WAIT_RELEASE;
          end
        end
        default: if (stable == '0) state_d = WAIT_PRESS;
      endcase
    end
    // A handshake in the same cycle frees the slot, so the new code wins over overrun.
    if (evt && (!key_valid_q || hs)) begin
      key_d       = oh.idx;
      key_valid_d = 1'b1;
      if (hs) overrun_d = 1'b0;
    end else if (evt) begin
      overrun_d = 1'b1;
    end else if (hs) begin
      key_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_PRESS;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign overrun   = overrun_q;
  assign pressed   = (stable != '0);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives rows from the held
// keys, and a scan-level reference model predicts every output each cycle.
module tb_keypad_scanner;

  localparam int NSV  = 4;
  localparam int DEB  = 3;
  localparam int SLOT = 1 << NSV;
  localparam int SCAN = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row, col, key;
  logic        key_valid, pressed, overrun;
  logic        key_ready = 1'b0;
  logic [15:0] keys = '0;

  int n_cmp = 0, n_fail = 0, ev_cnt = 0;
  logic kv_prev = 1'b0;

  keypad_scanner #(.NUMSVAR(NSV), .DEB_SCANS(DEB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key       (key),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .pressed   (pressed),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Physical matrix: a row reads low when a held key sits on a driven column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  // ---------------- reference model ----------------
  int          m_cnt = 0, m_match = 0;
  logic [15:0] k1 = '0, k2 = '0, m_snap = '0, m_prev = '0, m_stable = '0;
  bit          m_armed = 1'b1, m_pend = 1'b0, e_valid = 1'b0, e_ovr = 1'b0;
  logic [3:0]  m_code = '0, e_key = '0;

  task automatic model_step();
    int c, n;
    bit hs;
    if (!rst_n) begin
      m_cnt = 0; m_match = 0;
      k1 = '0; k2 = '0; m_snap = '0; m_prev = '0; m_stable = '0;
      m_armed = 1'b1; m_pend = 1'b0; m_code = '0;
      e_key = '0; e_valid = 1'b0; e_ovr = 1'b0;
      return;
    end
    hs = e_valid && key_ready;
    if (m_pend) begin
      if (!e_valid || hs) begin
        e_key = m_code; e_valid = 1'b1;
        if (hs) e_ovr = 1'b0;
      end else begin
        e_ovr = 1'b1;
      end
    end else if (hs) begin
      e_valid = 1'b0; e_ovr = 1'b0;
    end
    m_pend = 1'b0;
    if (m_cnt % SLOT == SLOT - 1) begin
      c = (m_cnt / SLOT) % 4;
      for (int r = 0; r < 4; r++) m_snap[4*r+c] = k2[4*r+c];
      if (c == 3) begin
        if (m_snap == m_prev) m_match = (m_match < DEB) ? m_match + 1 : DEB;
        else                  m_match = 1;
        m_prev = m_snap;
        if (m_match == DEB) begin
          m_stable = m_snap;
          n = $countones(m_stable);
          if (m_armed) begin
            if (n == 1) begin
              m_pend = 1'b1;
              for (int i = 0; i < 16; i++) if (m_stable[i]) m_code = 4'(i);
            end
            if (n >= 1) m_armed = 1'b0;
          end else if (n == 0) begin
            m_armed = 1'b1;
          end
        end
      end
    end
    m_cnt++;
    k2 = k1;
    k1 = keys;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  function automatic logic [3:0] exp_col();
    logic [3:0] one = 4'b0001;
    return ~(one << ((m_cnt / SLOT) % 4));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    chk("col", col, exp_col());
    chk("key", key, e_key);
    chk("key_valid", key_valid, e_valid);
    chk("pressed", pressed, m_stable != '0);
    chk("overrun", overrun, e_ovr);
  end

  initial forever begin
    @(negedge clk);
    if (key_valid === 1'b1 && kv_prev == 1'b0) ev_cnt++;
    kv_prev = key_valid;
  end

  // ---------------- stimulus helpers ----------------
  task automatic run(input int n, input bit rnd_rdy);
    repeat (n) begin
      @(negedge clk);
      if (rnd_rdy) key_ready = ($urandom_range(0, 99) < 30);
    end
    if (rnd_rdy) key_ready = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input int bound, output int lat);
    lat = 0;
    while (key_valid !== 1'b1 && lat < bound) begin
      @(negedge clk);
      lat++;
    end
    chk(nm, key_valid, 1'b1);
  endtask

  task automatic pulse_ready();
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat, ev0, sel, nb, a, b;
    logic [15:0] pat;

    repeat (3) @(negedge clk);
    chk("rst_col", col, 4'b1110);
    chk("rst_key", key, 4'h0);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_pressed", pressed, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    rst_n = 1'b1;

    repeat (SLOT) @(negedge clk);
    chk("col_slot1", col, 4'b1101);
    repeat (SLOT) @(negedge clk);
    chk("col_slot2", col, 4'b1011);
    repeat (SLOT) @(negedge clk);
    chk("col_slot3", col, 4'b0111);
    repeat (SLOT) @(negedge clk);
    chk("col_wrap", col, 4'b1110);
    run(10 * SCAN - 4 * SLOT, 1'b0);
    chk("idle_valid", key_valid, 1'b0);
    chk("idle_pressed", pressed, 1'b0);

    // single key at row 2, col 1
    ev0  = ev_cnt;
    keys = 16'h0200;
    wait_valid("k9_valid", 4 * SCAN, lat);
    chk("k9_latency_ok", lat <= 4 * SCAN, 1'b1);
    chk("k9_code", key, 4'h9);
    pulse_ready();
    chk("k9_drop", key_valid, 1'b0);
    keys = '0;
    run(5 * SCAN, 1'b0);
    chk("k9_rel_pressed", pressed, 1'b0);
    chk("k9_events", ev_cnt - ev0, 1);

    // bounce: key 6 toggles every scan, then held
    ev0 = ev_cnt;
    for (int i = 0; i < 6; i++) begin
      keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
      run(SCAN, 1'b0);
    end
    chk("bnc_no_early", ev_cnt - ev0, 0);
    keys = 16'h0040;
    wait_valid("bnc_valid", 6 * SCAN, lat);
    chk("bnc_late", lat > 2 * SCAN, 1'b1);
    chk("bnc_code", key, 4'h6);
    run(2, 1'b0);
    pulse_ready();
    keys = '0;
    run(5 * SCAN, 1'b0);
    chk("bnc_events", ev_cnt - ev0, 1);

    // chord: 0 then 5 while 0 held, then release 0 with 5 held
    ev0  = ev_cnt;
    keys = 16'h0001;
    run(5 * SCAN, 1'b0);
    chk("chord_first_valid", key_valid, 1'b1);
    keys = 16'h0021;
    run(5 * SCAN, 1'b0);
    keys = 16'h0020;
    run(5 * SCAN, 1'b0);
    chk("chord_pressed", pressed, 1'b1);
    keys = '0;
    run(5 * SCAN, 1'b0);
    chk("chord_events", ev_cnt - ev0, 1);
    chk("chord_key", key, 4'h0);
    chk("chord_overrun", overrun, 1'b0);
    pulse_ready();

    // overrun: 3 then C with no consumer
    keys = 16'h0008;
    run(5 * SCAN, 1'b0);
    keys = '0;
    run(5 * SCAN, 1'b0);
    keys = 16'h1000;
    run(5 * SCAN, 1'b0);
    chk("ovr_key", key, 4'h3);
    chk("ovr_flag", overrun, 1'b1);
    keys = '0;
    run(5 * SCAN, 1'b0);
    pulse_ready();
    chk("ovr_clear", overrun, 1'b0);
    chk("ovr_valid", key_valid, 1'b0);

    // asynchronous reset while a code is pending
    keys = 16'h0200;
    wait_valid("rst_pre_valid", 6 * SCAN, lat);
    run(10, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_col", col, 4'b1110);
    chk("arst_key", key, 4'h0);
    chk("arst_valid", key_valid, 1'b0);
    chk("arst_pressed", pressed, 1'b0);
    chk("arst_overrun", overrun, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_valid("rst_redetect_valid", 6 * SCAN, lat);
    chk("rst_redetect_key", key, 4'h9);
    pulse_ready();
    keys = '0;
    run(5 * SCAN, 1'b0);

    // randomized presses, chords, bounce and consumer back-pressure
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 9);
      pat = '0;
      if (sel < 6) begin
        a = $urandom_range(0, 15);
        pat[a] = 1'b1;
      end else if (sel < 8) begin
        a = $urandom_range(0, 15);
        b = $urandom_range(0, 15);
        pat[a] = 1'b1;
        pat[b] = 1'b1;
      end
      nb = $urandom_range(0, 3);
      for (int k = 0; k < nb; k++) begin
        keys = pat;
        run($urandom_range(1, 40), 1'b1);
        keys = '0;
        run($urandom_range(1, 40), 1'b1);
      end
      keys = pat;
      run($urandom_range(1, 5) * SCAN, 1'b1);
      keys = '0;
      run($urandom_range(1, 4) * SCAN, 1'b1);
    end
    key_ready = 1'b1;
    run(2 * SCAN, 1'b0);
    key_ready = 1'b0;
    chk("final_valid", key_valid, 1'b0);
    chk("final_pressed", pressed, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
